// File: rtl/muldiv_sequencer.sv
// Multi-cycle signed multiply / restoring divide engine with pipeline stall control.
// One iteration per cycle over magnitudes; sign fix-up is applied on the last iteration.
module muldiv_sequencer #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             stall,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result_lo,
    output logic [WIDTH-1:0] result_hi,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t               state_q, state_d;
    logic                 op_q, op_d;
    logic                 neg_q, neg_d;
    logic                 rem_neg_q, rem_neg_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]     opb_q, opb_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 dbz_q, dbz_d;
    logic [WIDTH-1:0]     res_lo_q, res_lo_d;
    logic [WIDTH-1:0]     res_hi_q, res_hi_d;

    logic [WIDTH-1:0]     a_mag, b_mag;
    logic [WIDTH:0]       mul_sum;
    logic [2*WIDTH-1:0]   mul_next;
    logic [WIDTH:0]       rem_sh;
    logic [WIDTH-1:0]     quo_sh;
    logic [WIDTH-1:0]     rem_sub;
    logic                 rem_ge;
    logic [2*WIDTH-1:0]   div_next;
    logic [2*WIDTH-1:0]   acc_next;
    logic [2*WIDTH-1:0]   prod;

    assign a_mag = a[WIDTH-1] ? (~a + 1'b1) : a;
    assign b_mag = b[WIDTH-1] ? (~b + 1'b1) : b;

    // Multiply: acc = {partial product, remaining multiplier bits}; carry kept in the shift.
    assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : '0);
    assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

    // Divide: acc = {remainder, quotient}; remainder widened by one bit for the shift.
    assign rem_sh   = acc_q[2*WIDTH-1:WIDTH-1];
    assign quo_sh   = {acc_q[WIDTH-2:0], 1'b0};
    assign rem_ge   = (rem_sh >= {1'b0, opb_q});
    assign rem_sub  = rem_sh[WIDTH-1:0] - opb_q;
    assign div_next = rem_ge ? {rem_sub, quo_sh[WIDTH-1:1], 1'b1}
                             : {rem_sh[WIDTH-1:0], quo_sh};

    assign acc_next = op_q ? div_next : mul_next;
    assign prod     = neg_q ? (~acc_next + 1'b1) : acc_next;

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        neg_d     = neg_q;
        rem_neg_d = rem_neg_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        opb_d     = opb_q;
        busy_d    = 1'b0;
        done_d    = 1'b0;
        dbz_d     = dbz_q;
        res_lo_d  = res_lo_q;
        res_hi_d  = res_hi_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_d      = op;
                    neg_d     = a[WIDTH-1] ^ b[WIDTH-1];
                    rem_neg_d = a[WIDTH-1];
                    opb_d     = b_mag;
                    dbz_d     = 1'b0;
                    if (op && (b == '0)) begin
                        state_d  = S_DONE;
                        done_d   = 1'b1;
                        dbz_d    = 1'b1;
                        res_lo_d = '1;
                        res_hi_d = a;
                    end else begin
                        state_d = S_RUN;
                        busy_d  = 1'b1;
                        cnt_d   = CW'(WIDTH);
                        acc_d   = {{WIDTH{1'b0}}, a_mag};
                    end
                end
            end
            S_RUN: begin
                acc_d = acc_next;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    if (op_q) begin
                        res_lo_d = neg_q ? (~acc_next[WIDTH-1:0] + 1'b1) : acc_next[WIDTH-1:0];
                        res_hi_d = rem_neg_q ? (~acc_next[2*WIDTH-1:WIDTH] + 1'b1)
                                             : acc_next[2*WIDTH-1:WIDTH];
                    end else begin
                        res_lo_d = prod[WIDTH-1:0];
                        res_hi_d = prod[2*WIDTH-1:WIDTH];
                    end
                end else begin
                    busy_d = 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            op_q      <= 1'b0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            cnt_q     <= '0;
            acc_q     <= '0;
            opb_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            dbz_q     <= 1'b0;
            res_lo_q  <= '0;
            res_hi_q  <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            neg_q     <= neg_d;
            rem_neg_q <= rem_neg_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            opb_q     <= opb_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            dbz_q     <= dbz_d;
            res_lo_q  <= res_lo_d;
            res_hi_q  <= res_hi_d;
        end
    end

    // Combinational from start so the MUL/DIV instruction is held in its first cycle.
    assign stall       = ((state_q == S_IDLE) && start) || busy_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign div_by_zero = dbz_q;
    assign result_lo   = res_lo_q;
    assign result_hi   = res_hi_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer: latency, stall window, signed results, abort on reset.
module tb_muldiv_sequencer;

    logic        clk;
    logic        rst;
    logic        start;
    logic        op;
    logic [63:0] a;
    logic [63:0] b;
    logic        stall;
    logic        busy;
    logic        done;
    logic [63:0] result_lo;
    logic [63:0] result_hi;
    logic        div_by_zero;

    int checks   = 0;
    int failures = 0;

    muldiv_sequencer #(.WIDTH(64)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .op         (op),
        .a          (a),
        .b          (b),
        .stall      (stall),
        .busy       (busy),
        .done       (done),
        .result_lo  (result_lo),
        .result_hi  (result_hi),
        .div_by_zero(div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check64(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Start held from cycle 0 through the done cycle; operands scrambled after accept.
    task automatic run_op(input string tag, input logic op_i, input logic [63:0] a_i,
                          input logic [63:0] b_i, input int exp_done,
                          input logic [63:0] exp_lo, input logic [63:0] exp_hi,
                          input logic exp_dbz);
        int          ndone, dcyc, nstall;
        logic [63:0] lo_s, hi_s;
        logic        dbz_s, dbz_after;
        ndone = 0; dcyc = -1; nstall = 0;
        lo_s = '0; hi_s = '0; dbz_s = 1'b0; dbz_after = 1'b0;
        start = 1'b1; op = op_i; a = a_i; b = b_i;
        for (int cyc = 0; cyc <= exp_done + 1; cyc++) begin
            @(negedge clk);
            if (stall) nstall++;
            if (done) begin
                ndone++; dcyc = cyc;
                lo_s = result_lo; hi_s = result_hi; dbz_s = div_by_zero;
            end
            if (cyc == exp_done + 1) dbz_after = div_by_zero;
            @(posedge clk); #1;
            if (cyc == 0) begin
                a  = {$urandom, $urandom};
                b  = {$urandom, $urandom};
                op = ~op_i;
            end
            if (cyc == exp_done) start = 1'b0;
        end
        check64({tag, "_ndone"}, 64'(ndone), 64'd1);
        check64({tag, "_done_cyc"}, 64'(dcyc), 64'(exp_done));
        check64({tag, "_stall_cycles"}, 64'(nstall), 64'(exp_done));
        check64({tag, "_lo"}, lo_s, exp_lo);
        check64({tag, "_hi"}, hi_s, exp_hi);
        check64({tag, "_dbz"}, 64'(dbz_s), 64'(exp_dbz));
        check64({tag, "_dbz_hold"}, 64'(dbz_after), 64'(exp_dbz));
    endtask

    initial begin
        int          nd, d1c, d2c;
        logic [63:0] r1, r2;
        logic        stall65;

        rst = 1'b1; start = 1'b0; op = 1'b0; a = '0; b = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check64("rst_busy", 64'(busy), 64'd0);
        check64("rst_done", 64'(done), 64'd0);
        check64("rst_stall", 64'(stall), 64'd0);
        check64("rst_dbz", 64'(div_by_zero), 64'd0);
        check64("rst_lo", result_lo, 64'd0);
        check64("rst_hi", result_hi, 64'd0);
        @(posedge clk); #1;

        run_op("mul_6x7", 1'b0, 64'd6, 64'd7, 65, 64'd42, 64'd0, 1'b0);
        run_op("mul_m3x5", 1'b0, -64'sd3, 64'd5, 65,
               64'hFFFF_FFFF_FFFF_FFF1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        run_op("div_123_0", 1'b1, 64'd123, 64'd0, 1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd123, 1'b1);
        run_op("div_m100_7", 1'b1, -64'sd100, 64'd7, 65,
               64'hFFFF_FFFF_FFFF_FFF2, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0);
        run_op("div_minneg_m1", 1'b1, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 65,
               64'h8000_0000_0000_0000, 64'd0, 1'b0);

        // Abort the same divide with rst during RUN cycle 30.
        start = 1'b1; op = 1'b1; a = 64'h8000_0000_0000_0000; b = '1;
        @(posedge clk); #1 start = 1'b0;
        repeat (29) @(posedge clk);
        #1;
        @(negedge clk);
        check64("abort_busy_c30", 64'(busy), 64'd1);
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check64("abort_busy", 64'(busy), 64'd0);
        check64("abort_stall", 64'(stall), 64'd0);
        check64("abort_done", 64'(done), 64'd0);
        check64("abort_lo", result_lo, 64'd0);
        check64("abort_hi", result_hi, 64'd0);
        nd = 0;
        repeat (80) begin
            @(negedge clk);
            if (done) nd++;
        end
        check64("abort_no_done", 64'(nd), 64'd0);
        @(posedge clk); #1;

        // Back-to-back multiplies with start held through the first DONE cycle.
        nd = 0; d1c = -1; d2c = -1; r1 = '0; r2 = '0; stall65 = 1'b1;
        start = 1'b1; op = 1'b0; a = 64'd2; b = 64'd3;
        for (int cyc = 0; cyc <= 133; cyc++) begin
            @(negedge clk);
            if (cyc == 65) stall65 = stall;
            if (done) begin
                nd++;
                if (nd == 1) begin d1c = cyc; r1 = result_lo; end
                else if (nd == 2) begin d2c = cyc; r2 = result_lo; end
            end
            @(posedge clk); #1;
            if (cyc == 64) begin a = 64'd4; b = 64'd5; end
            if (cyc == 66) start = 1'b0;
        end
        check64("b2b_ndone", 64'(nd), 64'd2);
        check64("b2b_done1_cyc", 64'(d1c), 64'd65);
        check64("b2b_done2_cyc", 64'(d2c), 64'd131);
        check64("b2b_res1", r1, 64'd6);
        check64("b2b_res2", r2, 64'd20);
        check64("b2b_stall_done", 64'(stall65), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/muldiv_sequencer.md
# muldiv_sequencer

Multi-cycle signed multiply/divide engine and stall controller for the 64-bit single-cycle CPU. When the decoder selects the MUL or DIV ALU operation, this block latches the operands, runs a WIDTH-iteration shift-add multiply or restoring divide, and holds the pipeline with `stall` until the result is ready. It sits beside the main ALU; the write-back mux takes `result_lo` in place of the ALU result in the cycle `done` is high.

## Interface
- `WIDTH`, 64, operand/result width in bits; iteration count equals WIDTH.

- `clk`  input  1  rising-edge clock, the only clock.
- `rst`  input  1  synchronous, active-high reset.
- `start`  input  1  high while the current instruction decodes to MUL or DIV.
- `op`  input  1  0 = multiply, 1 = divide; sampled with `start`.
- `a`  input  WIDTH  rs operand, two's complement; sampled with `start`.
- `b`  input  WIDTH  rt operand, two's complement; sampled with `start`.
- `stall`  output  1  freezes PC and register-file write while high.
- `busy`  output  1  high in RUN.
- `done`  output  1  one-cycle pulse; results valid and CPU commits.
- `result_lo`  output  WIDTH  product low half, or quotient.
- `result_hi`  output  WIDTH  product high half, or remainder.
- `div_by_zero`  output  1  set with `done` when a divide had `b == 0`.

## Operation
- States: IDLE, RUN, DONE. Reset value: IDLE, with `busy`, `done`, `div_by_zero`, `result_lo`, `result_hi` and the iteration counter all 0.
- IDLE, `start=1`: latch `op`, |a|, |b| and the result sign. Result sign is sign(a) XOR sign(b) for both product and quotient. Remainder sign equals sign(a).
  - Divide with `b == 0`: go to DONE. Set `result_lo` to all ones, `result_hi` to `a`, and `div_by_zero` to 1.
  - Otherwise: load counter = WIDTH and go to RUN.
- RUN: perform one iteration per cycle and decrement the counter. When the counter reaches 1, apply sign correction to the magnitudes and go to DONE.
  - Multiply: 2·WIDTH-bit accumulator. Each cycle, if the multiplier LSB is 1, add the multiplicand into the high half, then shift right 1.
  - Divide: shift the remainder:quotient pair left 1. Subtract |b| from the remainder; if the result is non-negative, keep it and set the quotient LSB to 1.
- DONE: drive `done=1` and go to IDLE unconditionally. `start` is ignored here, because the same instruction is still decoded during this cycle.
- `result_lo`, `result_hi` and `div_by_zero` hold their values until the next accepted `start` or reset. `div_by_zero` clears on the next accepted `start`.
- `start` during RUN is ignored. `op`, `a` and `b` may change freely after the accept cycle.
- Arithmetic rules:
  - Multiply returns the full signed 2·WIDTH product.
  - Divide truncates toward zero.
  - Most-negative / −1: magnitude 2^(WIDTH−1) wraps, so `result_lo` = 0x8000_0000_0000_0000 and `result_hi` = 0. No overflow flag.
- `stall` = (IDLE & `start`) | RUN. This is combinational from `start` in IDLE, so the instruction is held in its first cycle. `stall` is low in DONE.
- Reset mid-operation (any state): the next state is IDLE with all outputs at reset values. No `done` is produced for the aborted operation.

## Timing
- Accept edge = end of cycle 0 (IDLE with `start=1`).
- Normal operation:
  - RUN occupies cycles 1..WIDTH.
  - `done` is high in cycle WIDTH+1 (cycle 65 at default WIDTH), with results valid in the same cycle.
  - `stall` is high in cycles 0..WIDTH.
- Divide-by-zero: `done` and results are valid in cycle 1. `stall` is high in cycle 0 only.
- Back-to-back MUL/DIV: the next instruction's `start` is seen in IDLE in cycle WIDTH+2 and is accepted there.
- `busy` is registered. `done` is decoded from the registered state with no combinational input path.

## Test plan
- a=6, b=7, op=0, start held: `stall` high cycles 0–64; `done` in cycle 65; `result_lo`=42, `result_hi`=0; `stall` low in cycle 65.
- a=−3, b=5, op=0: `result_lo`=0xFFFF_FFFF_FFFF_FFF1, `result_hi`=0xFFFF_FFFF_FFFF_FFFF.
- a=−100, b=7, op=1: `result_lo`=0xFFFF_FFFF_FFFF_FFF2 (−14), `result_hi`=0xFFFF_FFFF_FFFF_FFFE (−2), `div_by_zero`=0.
- a=123, b=0, op=1: `done` in cycle 1; `result_lo`=all ones, `result_hi`=123, `div_by_zero`=1; a following valid divide clears `div_by_zero`.
- Most-negative / −1: `result_lo`=0x8000_0000_0000_0000, `result_hi`=0; then `rst` pulsed in RUN cycle 30 → IDLE next cycle, `busy`/`stall`/`done`=0, results 0, no `done` afterwards.
- Two consecutive MULs (2×3, then 4×5), with `start` held through the DONE cycle of the first: exactly one `done` per op, in cycles 65 and 131; results 6 then 20.
